// File: rtl/note_lane_queue.sv
// note_lane_queue: captures legal map-strobed notes into a FIFO and presents them with lane decode, handshake and minimum spacing
module note_lane_queue #(
  parameter int DEPTH  = 8,
  parameter int GAP    = 3,
  parameter int X_BASE = 100,
  parameter int X_STEP = 4,
  parameter int LANES  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     map,
  input  logic                     data_en,
  input  logic [7:0]               data,
  input  logic                     note_ready,
  output logic                     note_valid,
  output logic [7:0]               note_x,
  output logic [2:0]               note_lane,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     bad_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_M1 = GAP > 0 ? GW'(GAP - 1) : '0;
  localparam logic [7:0] XB = 8'(X_BASE);
  localparam logic [7:0] XS = 8'(X_STEP);
  localparam logic [7:0] XMAX = 8'(X_BASE + X_STEP * (LANES - 1));
  typedef enum logic [1:0] {IDLE, SHOW, WAIT} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0] x_q, x_d;
  logic [2:0] lane_q, lane_d;
  logic ovf_q, ovf_d, bad_q, bad_d;
  logic [10:0] mem [DEPTH];
  logic [7:0] off;
  logic push, legal, full, do_push, pop, has;
  assign push = map & data_en;
  assign off = data - XB;
  assign legal = data >= XB && data <= XMAX && (off % XS) == 8'd0;
  assign full = count_q == CW'(DEPTH);
  assign has = count_q != '0;
  assign do_push = push & legal & ~full;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      x_q     <= '0;
      lane_q  <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      x_q     <= x_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= {3'(off / XS), data};
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    case (state_q)
      IDLE: state_d = has ? SHOW : IDLE;
      SHOW:
        if (note_ready) begin
          if (GAP == 0) state_d = has ? SHOW : IDLE;
          else begin
            state_d = WAIT;
            gap_d = GAP_M1;
          end
        end
      WAIT: begin
        state_d = gap_q == '0 ? IDLE : WAIT;
        gap_d = gap_q == '0 ? gap_q : gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pop = has && (state_q == IDLE || (state_q == SHOW && note_ready && GAP == 0));
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(do_push) - CW'(pop);
    x_d = pop ? mem[rd_q][7:0] : x_q;
    lane_d = pop ? mem[rd_q][10:8] : lane_q;
    ovf_d = ovf_q | (push & legal & full);
    bad_d = bad_q | (push & ~legal);
  end
  assign note_valid = state_q == SHOW;
  assign note_x = x_q;
  assign note_lane = lane_q;
  assign count = count_q;
  assign overflow = ovf_q;
  assign bad_data = bad_q;
endmodule
